// File: rtl/sample_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// sample_fetch_arbiter
//
// Shares one read port of the encoded sample memory between NUM_CHANNELS
// channels. Each channel can hold one pending request, with its address
// buffered. Pending requests are granted round-robin, one per cycle. Read data
// comes back to the requester with a one-hot valid strobe, in grant order.
//
// Handshake semantics: there is no ready/backpressure anywhere. ch_req is a
// one-cycle strobe that is always accepted; a repeat strobe before the grant
// only replaces the buffered address. ch_valid is a one-cycle one-hot strobe
// that the owning channel must consume in the cycle it fires. mem_rd is a
// one-cycle read strobe; mem_rdata is taken exactly MEM_LATENCY cycles later.
//
// Optional feature macro: FETCH_PRIO_EN
//   defined   : channel 0 has strict priority and does not move the RR pointer
//   undefined : pure round-robin over all channels
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active low
//   ch_req     in   per-channel request strobe
//   ch_addr    in   packed request addresses, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   ch_valid   out  one-hot return strobe
//   ch_data    out  returned sample delta (shared)
//   mem_addr   out  memory read address
//   mem_rd     out  memory read strobe
//   mem_rdata  in   memory read data, MEM_LATENCY cycles after mem_rd
//   busy       out  any request pending or in flight
// -----------------------------------------------------------------------------
module sample_fetch_arbiter #(
   parameter int NUM_CHANNELS = 4,
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 12,
   parameter int MEM_LATENCY  = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_CHANNELS-1:0]            ch_req,
   input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] ch_addr,
   output logic [NUM_CHANNELS-1:0]            ch_valid,
   output logic [DATA_WIDTH-1:0]              ch_data,
   output logic [ADDR_WIDTH-1:0]              mem_addr,
   output logic                               mem_rd,
   input  logic [DATA_WIDTH-1:0]              mem_rdata,
   output logic                               busy
);

   localparam int IW = $clog2(NUM_CHANNELS);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHANNELS - 1);

   logic [NUM_CHANNELS-1:0] pending_q, pending_d;
   logic [ADDR_WIDTH-1:0]   addr_buf_q [NUM_CHANNELS];
   logic [IW-1:0]           rr_q, rr_d;

   logic                    gnt_vld;
   logic [IW-1:0]           gnt_idx;
   logic [IW-1:0]           cand;
   int                      sum;

   logic                    mem_rd_q;
   logic [ADDR_WIDTH-1:0]   mem_addr_q;
   logic [IW-1:0]           rd_idx_q;      // channel owning the read now on the port

   logic [MEM_LATENCY-1:0]  tag_vld_q;
   logic [IW-1:0]           tag_idx_q [MEM_LATENCY];

   logic [NUM_CHANNELS-1:0] ch_valid_q;
   logic [DATA_WIDTH-1:0]   ch_data_q;
   logic [NUM_CHANNELS-1:0] ret_onehot;

   // Round-robin search. The loop runs from the farthest offset down to the
   // pointer itself so the closest pending channel is the last one written.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      sum     = 0;
      rr_d    = rr_q;
      for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
         sum = int'(rr_q) + k;
         if (sum >= NUM_CHANNELS) sum = sum - NUM_CHANNELS;
         cand = IW'(sum);
         if (pending_q[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
      if (gnt_vld) rr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IW'(1);
`ifdef FETCH_PRIO_EN
      // Channel 0 overrides the rotation and leaves the pointer where it is.
      if (pending_q[0]) begin
         gnt_vld = 1'b1;
         gnt_idx = '0;
         rr_d    = rr_q;
      end
`endif
   end

   // Grant clears first, capture sets afterwards: a channel granted and
   // re-requested on the same edge stays pending for a second fetch.
   always_comb begin
      pending_d = pending_q;
      if (gnt_vld) pending_d[gnt_idx] = 1'b0;
      pending_d = pending_d | ch_req;
   end

   always_comb begin
      ret_onehot = NUM_CHANNELS'(1) << tag_idx_q[MEM_LATENCY-1];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pending_q  <= '0;
         rr_q       <= '0;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= '0;
         rd_idx_q   <= '0;
         tag_vld_q  <= '0;
         ch_valid_q <= '0;
         ch_data_q  <= '0;
         for (int i = 0; i < NUM_CHANNELS; i++) addr_buf_q[i] <= '0;
         for (int k = 0; k < MEM_LATENCY; k++) tag_idx_q[k] <= '0;
      end else begin
         pending_q <= pending_d;
         rr_q      <= rr_d;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (ch_req[i]) addr_buf_q[i] <= ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         end

         // The grant reads the buffer value from before this edge's capture.
         mem_rd_q <= gnt_vld;
         if (gnt_vld) begin
            mem_addr_q <= addr_buf_q[gnt_idx];
            rd_idx_q   <= gnt_idx;
         end

         // Tag enters the pipe as the read leaves the port, so the last
         // stage lines up with the cycle mem_rdata is valid.
         tag_vld_q[0] <= mem_rd_q;
         tag_idx_q[0] <= rd_idx_q;
         for (int k = 1; k < MEM_LATENCY; k++) begin
            tag_vld_q[k] <= tag_vld_q[k-1];
            tag_idx_q[k] <= tag_idx_q[k-1];
         end

         if (tag_vld_q[MEM_LATENCY-1]) begin
            ch_valid_q <= ret_onehot;
            ch_data_q  <= mem_rdata;
         end else begin
            ch_valid_q <= '0;
         end
      end
   end

   assign mem_rd   = mem_rd_q;
   assign mem_addr = mem_addr_q;
   assign ch_valid = ch_valid_q;
   assign ch_data  = ch_data_q;
   assign busy     = (|pending_q) | (|tag_vld_q) | mem_rd_q;

endmodule

// File: tb/tb_sample_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for sample_fetch_arbiter (4 channels, 32-bit addresses, 12-bit data,
// memory latency 1). A behavioural memory returns mem_f(addr) one cycle after
// each read and random junk otherwise. Expected memory addresses and returned
// {ch_valid, ch_data} words are queued when requests are driven and compared
// in order by a monitor on the falling edge.
// -----------------------------------------------------------------------------
module tb_sample_fetch_arbiter;

   localparam int N   = 4;
   localparam int AW  = 32;
   localparam int DW  = 12;
   localparam int LAT = 1;

   // ---------------- clock / reset / DUT ----------------
   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    ch_req;
   logic [N*AW-1:0] ch_addr;
   logic [N-1:0]    ch_valid;
   logic [DW-1:0]   ch_data;
   logic [AW-1:0]   mem_addr;
   logic            mem_rd;
   logic [DW-1:0]   mem_rdata;
   logic            busy;

   always #5 clk = ~clk;

   sample_fetch_arbiter #(
      .NUM_CHANNELS(N),
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .MEM_LATENCY (LAT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ch_req   (ch_req),
      .ch_addr  (ch_addr),
      .ch_valid (ch_valid),
      .ch_data  (ch_data),
      .mem_addr (mem_addr),
      .mem_rd   (mem_rd),
      .mem_rdata(mem_rdata),
      .busy     (busy)
   );

   // ---------------- memory model ----------------
   function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
      if (a == 32'h10) return 12'hABC;
      return a[11:0] * 12'd5 + a[31:20] + 12'h3C5;
   endfunction

   logic [DW-1:0] rd_pipe [LAT];
   always @(posedge clk) begin
      rd_pipe[0] <= (mem_rd === 1'b1) ? mem_f(mem_addr) : DW'($urandom_range(0, 4095));
      for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign mem_rdata = rd_pipe[LAT-1];

   // ---------------- scoreboard ----------------
   int tests = 0;
   int fails = 0;
   logic mon_en = 1'b0;
   logic [AW-1:0]   exp_addr_q[$];
   logic [N+DW-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (mem_rd === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_mem_rd: got addr %h expected no read (t=%0t)", mem_addr, $time);
            end else begin
               check("mem_addr_order", mem_addr, exp_addr_q.pop_front());
            end
         end
         if (ch_valid !== '0) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_ch_valid: got %b/%h expected no return (t=%0t)", ch_valid, ch_data, $time);
            end else begin
               check("return_order", 32'({ch_valid, ch_data}), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clr_req();
      ch_req = '0;
      for (int c = 0; c < N; c++) ch_addr[c*AW +: AW] = AW'($urandom_range(0, 32'hFFFF_FFFF));
   endtask

   task automatic set_req(input int ch, input logic [AW-1:0] a);
      ch_req[ch] = 1'b1;
      ch_addr[ch*AW +: AW] = a;
   endtask

   task automatic expect_fetch(input int ch, input logic [AW-1:0] a);
      exp_addr_q.push_back(a);
      exp_q.push_back({N'(1) << ch, mem_f(a)});
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      clr_req();
      repeat (n) @(negedge clk);
      rst = 1'b1;
   endtask

   // Single uncontended fetch; returns at the negedge of cycle 5.
   task automatic solo(input int ch, input logic [AW-1:0] a);
      set_req(ch, a);
      expect_fetch(ch, a);
      @(negedge clk);
      clr_req();
      repeat (4) @(negedge clk);
   endtask

   // ---------------- table-driven vectors ----------------
   typedef struct {
      int            ch;
      logic [AW-1:0] addr;
      logic [N-1:0]  exp_valid;
      logic [DW-1:0] exp_data;
   } vec_t;
   vec_t vecs [4];

   task automatic run_vec(input vec_t v);
      set_req(v.ch, v.addr);
      exp_addr_q.push_back(v.addr);
      exp_q.push_back({v.exp_valid, v.exp_data});
      @(negedge clk);                                     // cycle 1
      clr_req();
      check("vec_busy_c1", 32'(busy), 32'd1);
      check("vec_mem_rd_c1", 32'(mem_rd), 32'd0);
      @(negedge clk);                                     // cycle 2
      check("vec_mem_rd_c2", 32'(mem_rd), 32'd1);
      @(negedge clk);                                     // cycle 3
      check("vec_ch_valid_c3", 32'(ch_valid), 32'd0);
      @(negedge clk);                                     // cycle 4
      check("vec_ch_valid_c4", 32'(ch_valid), 32'(v.exp_valid));
      check("vec_ch_data_c4", 32'(ch_data), 32'(v.exp_data));
      @(negedge clk);                                     // cycle 5
      check("vec_ch_valid_c5", 32'(ch_valid), 32'd0);
      check("vec_busy_c5", 32'(busy), 32'd0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      vecs[0] = '{2, 32'h0000_0010, 4'b0100, 12'hABC};
      vecs[1] = '{0, 32'h0000_0055, 4'b0001, 12'h56E};
      vecs[2] = '{3, 32'hFFFF_FFFF, 4'b1000, mem_f(32'hFFFF_FFFF)};
      vecs[3] = '{1, 32'h0000_0000, 4'b0010, mem_f(32'h0)};

      // Reset held with every channel requesting.
      rst     = 1'b0;
      ch_req  = '1;
      ch_addr = '0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("rst_ch_valid", 32'(ch_valid), 32'd0);
         check("rst_mem_rd", 32'(mem_rd), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
      end
      rst = 1'b1;
      clr_req();
      mon_en = 1'b1;

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      // All four channels at once from pointer 0.
      do_reset(2);
      for (int c = 0; c < N; c++) begin
         set_req(c, AW'(32'h100 + c));
         expect_fetch(c, AW'(32'h100 + c));
      end
      @(negedge clk);
      clr_req();
      for (int c = 2; c <= 7; c++) begin
         @(negedge clk);
         check("burst_mem_rd", 32'(mem_rd), 32'(c <= 5));
         check("burst_ch_valid", 32'(ch_valid), (c >= 4) ? 32'(4'b0001 << (c - 4)) : 32'd0);
      end
      @(negedge clk);
      check("burst_busy_idle", 32'(busy), 32'd0);

      // Pointer wrap: grant ch2 (pointer -> 3), then ch0 and ch3 together.
      solo(2, 32'h200);
      set_req(0, 32'h300);
      set_req(3, 32'h303);
      expect_fetch(3, 32'h303);
      expect_fetch(0, 32'h300);
      @(negedge clk);
      clr_req();
      @(negedge clk);
      check("wrap_first", mem_addr, 32'h303);
      @(negedge clk);
      check("wrap_second", mem_addr, 32'h300);
      repeat (3) @(negedge clk);

      // Overwrite: pointer to 0 via ch3, then ch1 re-requests while ch0 wins.
      solo(3, 32'h400);
      set_req(0, 32'h40);
      set_req(1, 32'h20);
      expect_fetch(0, 32'h40);
      expect_fetch(1, 32'h30);
      @(negedge clk);
      clr_req();
      set_req(1, 32'h30);
      @(negedge clk);
      clr_req();
      check("ovw_ch0", mem_addr, 32'h40);
      @(negedge clk);
      check("ovw_ch1_latest", mem_addr, 32'h30);
      @(negedge clk);
      check("ovw_single_fetch", 32'(mem_rd), 32'd0);
      repeat (2) @(negedge clk);

      // Capture and grant of the same channel on one edge: two fetches.
      set_req(2, 32'h50);
      expect_fetch(2, 32'h50);
      expect_fetch(2, 32'h51);
      @(negedge clk);
      clr_req();
      set_req(2, 32'h51);
      @(negedge clk);
      clr_req();
      check("same_edge_old", mem_addr, 32'h50);
      @(negedge clk);
      check("same_edge_new", mem_addr, 32'h51);
      @(negedge clk);
      check("same_edge_done", 32'(mem_rd), 32'd0);
      repeat (2) @(negedge clk);

      // Reset while a read is on the port: its return must never appear.
      set_req(0, 32'h60);
      exp_addr_q.push_back(32'h60);
      @(negedge clk);
      clr_req();
      @(negedge clk);
      check("midrst_mem_rd", 32'(mem_rd), 32'd1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("midrst_ch_valid", 32'(ch_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      for (int c = 0; c <= LAT; c++) begin
         @(negedge clk);
         check("midrst_ch_valid", 32'(ch_valid), 32'd0);
         check("midrst_busy", 32'(busy), 32'd0);
      end

      // Channel 0 strobing every cycle while channel 1 waits.
      do_reset(2);
`ifdef FETCH_PRIO_EN
      for (int k = 0; k < 5; k++) expect_fetch(0, AW'(32'h80 + k));
      expect_fetch(1, 32'h71);
`else
      expect_fetch(0, 32'h80);
      expect_fetch(1, 32'h71);
      expect_fetch(0, 32'h82);
      expect_fetch(0, 32'h83);
      expect_fetch(0, 32'h84);
`endif
      set_req(0, 32'h80);
      set_req(1, 32'h71);
      for (int k = 1; k < 5; k++) begin
         @(negedge clk);
         clr_req();
         set_req(0, AW'(32'h80 + k));
`ifndef FETCH_PRIO_EN
         if (k == 3) check("rr_fair_ch1", mem_addr, 32'h71);
`endif
      end
      @(negedge clk);                                     // cycle 5
      clr_req();
      @(negedge clk);                                     // cycle 6
      check("starve_last_ch0", mem_addr, 32'h84);
      @(negedge clk);                                     // cycle 7
`ifdef FETCH_PRIO_EN
      check("prio_ch1_after_stop", mem_addr, 32'h71);
      check("prio_ch1_rd", 32'(mem_rd), 32'd1);
`else
      check("rr_idle_after", 32'(mem_rd), 32'd0);
`endif
      repeat (6) @(negedge clk);

      check("exp_addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      check("final_busy", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
